// File: rtl/bcd_pkg.sv
// Shared constants for the BCD display blocks: segment patterns ({g,f,e,d,c,b,a},
// active-high), the largest legal BCD digit and the digit-count width.
package bcd_pkg;

   localparam int CNT_W = 4;

   localparam logic [3:0] BCD_MAX = 4'd9;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder. Codes above 9 fall back to the '0'
// pattern so a corrupted digit never lights a random shape.
module bcd_to_seg7
   import bcd_pkg::*;
(
   input  logic [3:0] i_bcd,
   output logic [6:0] o_seg
);

   always_comb begin
      case (i_bcd)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         default: o_seg = SEG_0;
      endcase
   end

endmodule

// File: rtl/bcd_digit_display.sv
// Calculator-style BCD entry buffer driving a time-multiplexed common-cathode
// 7-segment display with leading-zero blanking.
module bcd_digit_display
   import bcd_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 50000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [3:0]            digit_in,
   input  logic                  digit_valid,
   input  logic                  clear,
   output logic [4*DIGITS-1:0]   value_bcd,
   output logic [CNT_W-1:0]      count,
   output logic                  err,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     dig_sel
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int IW = $clog2(DIGITS);

   localparam logic [PW-1:0]    PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0]    SCAN_LAST  = IW'(DIGITS - 1);
   localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DIGITS);

   logic [4*DIGITS-1:0] r_value;
   logic [CNT_W-1:0]    r_count;
   logic                r_err;
   logic [PW-1:0]       r_presc;
   logic [IW-1:0]       r_scan;
   logic [6:0]          r_seg;
   logic [DIGITS-1:0]   r_dig_sel;

   logic [3:0]          w_digit;
   logic [6:0]          w_seg_dec;
   logic                w_blank;
   logic [DIGITS-1:0]   w_sel;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c >= CNT_FULL) ? CNT_FULL : c + 1'b1;
   endfunction

   // Entry buffer: clear beats a strobe, and an out-of-range digit only pulses err.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_value <= '0;
         r_count <= '0;
         r_err   <= 1'b0;
      end else if (clear) begin
         r_value <= '0;
         r_count <= '0;
         r_err   <= 1'b0;
      end else if (digit_valid && (digit_in <= BCD_MAX)) begin
         r_value <= {r_value[4*DIGITS-5:0], digit_in};
         r_count <= sat_inc(r_count);
         r_err   <= 1'b0;
      end else if (digit_valid) begin
         r_err   <= 1'b1;
      end else begin
         r_err   <= 1'b0;
      end
   end

   // Scan timing runs independently of entry activity.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc <= '0;
         r_scan  <= '0;
      end else if (r_presc == PRESC_LAST) begin
         r_presc <= '0;
         r_scan  <= (r_scan == SCAN_LAST) ? '0 : r_scan + 1'b1;
      end else begin
         r_presc <= r_presc + 1'b1;
      end
   end

   always_comb begin
      w_digit = 4'd0;
      for (int k = 0; k < DIGITS; k++) begin
         if (r_scan == IW'(k)) w_digit = r_value[4*k +: 4];
      end
   end

   // Digit 0 is never blanked so an empty buffer still shows a single '0'.
   assign w_blank = (CNT_W'(r_scan) >= r_count) && (r_scan != '0);
   assign w_sel   = DIGITS'(1) << r_scan;

   bcd_to_seg7 u_dec (
      .i_bcd (w_digit),
      .o_seg (w_seg_dec)
   );

   // Display stage: seg and dig_sel change together on one edge, glitch-free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg     <= SEG_BLANK;
         r_dig_sel <= DIGITS'(1);
      end else begin
         r_seg     <= w_blank ? SEG_BLANK : w_seg_dec;
         r_dig_sel <= w_sel;
      end
   end

   assign value_bcd = r_value;
   assign count     = r_count;
   assign err       = r_err;
   assign seg       = r_seg;
   assign dig_sel   = r_dig_sel;

endmodule

// File: tb/tb_bcd_digit_display.sv
// Directed bench for bcd_digit_display with DIGITS = 4 and SCAN_DIV = 4.
module tb_bcd_digit_display;

   localparam int DIGITS   = 4;
   localparam int SCAN_DIV = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  digit_in = 4'd0;
   logic        digit_valid = 1'b0;
   logic        clear = 1'b0;
   logic [15:0] value_bcd;
   logic [3:0]  count;
   logic        err;
   logic [6:0]  seg;
   logic [3:0]  dig_sel;

   int n_vec  = 0;
   int n_miss = 0;

   bcd_digit_display #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .digit_in    (digit_in),
      .digit_valid (digit_valid),
      .clear       (clear),
      .value_bcd   (value_bcd),
      .count       (count),
      .err         (err),
      .seg         (seg),
      .dig_sel     (dig_sel)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic strobe(input logic [3:0] d);
      digit_in    = d;
      digit_valid = 1'b1;
      @(negedge clk);
      digit_valid = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic wait_sel(input int i, output bit ok);
      logic [3:0] want;
      want = 4'b0001 << i;
      ok   = 1'b0;
      for (int t = 0; t < 40; t++) begin
         if (dig_sel === want) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_vec++; if (value_bcd !== 16'h0000) begin n_miss++; $display("FAIL reset value_bcd: got %h want 0000", value_bcd); end
      n_vec++; if (count !== 4'd0)         begin n_miss++; $display("FAIL reset count: got %0d want 0", count); end
      n_vec++; if (err !== 1'b0)           begin n_miss++; $display("FAIL reset err: got %b want 0", err); end
      n_vec++; if (seg !== 7'h00)          begin n_miss++; $display("FAIL reset seg: got %h want 00", seg); end
      n_vec++; if (dig_sel !== 4'b0001)    begin n_miss++; $display("FAIL reset dig_sel: got %b want 0001", dig_sel); end
      rst_n = 1'b1;
   endtask

   task automatic test_scan();
      int         idx;
      logic [3:0] exp_sel;
      logic [6:0] exp_seg;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         idx     = ((n - 1) / 4) % 4;
         exp_sel = 4'b0001 << idx;
         exp_seg = (idx == 0) ? 7'h3F : 7'h00;
         n_vec++; if (dig_sel !== exp_sel) begin n_miss++; $display("FAIL scan dig_sel edge %0d: got %b want %b", n, dig_sel, exp_sel); end
         n_vec++; if (seg !== exp_seg)     begin n_miss++; $display("FAIL scan seg edge %0d: got %h want %h", n, seg, exp_seg); end
      end
   endtask

   task automatic test_entry();
      logic [6:0] exp_seg [4];
      bit ok;
      strobe(4'd1);
      n_vec++; if (value_bcd !== 16'h0001 || count !== 4'd1) begin n_miss++; $display("FAIL entry 1st: got %h/%0d want 0001/1", value_bcd, count); end
      strobe(4'd2);
      n_vec++; if (value_bcd !== 16'h0012 || count !== 4'd2) begin n_miss++; $display("FAIL entry 2nd: got %h/%0d want 0012/2", value_bcd, count); end
      strobe(4'd3);
      n_vec++; if (value_bcd !== 16'h0123 || count !== 4'd3) begin n_miss++; $display("FAIL entry 3rd: got %h/%0d want 0123/3", value_bcd, count); end
      @(negedge clk);
      exp_seg = '{7'h4F, 7'h5B, 7'h06, 7'h00};
      for (int i = 0; i < 4; i++) begin
         wait_sel(i, ok);
         n_vec++;
         if (!ok || seg !== exp_seg[i]) begin
            n_miss++;
            $display("FAIL entry display digit %0d: seg %h dig_sel %b want seg %h", i, seg, dig_sel, exp_seg[i]);
         end
      end
   endtask

   task automatic test_saturate();
      logic [6:0] exp_seg [4];
      bit ok;
      do_clear();
      strobe(4'd9); strobe(4'd8); strobe(4'd7); strobe(4'd6);
      n_vec++; if (value_bcd !== 16'h9876 || count !== 4'd4) begin n_miss++; $display("FAIL saturate full: got %h/%0d want 9876/4", value_bcd, count); end
      strobe(4'd5);
      n_vec++; if (value_bcd !== 16'h8765 || count !== 4'd4) begin n_miss++; $display("FAIL saturate drop: got %h/%0d want 8765/4", value_bcd, count); end
      @(negedge clk);
      exp_seg = '{7'h6D, 7'h7D, 7'h07, 7'h7F};
      for (int i = 0; i < 4; i++) begin
         wait_sel(i, ok);
         n_vec++;
         if (!ok || seg !== exp_seg[i]) begin
            n_miss++;
            $display("FAIL saturate display digit %0d: seg %h dig_sel %b want seg %h", i, seg, dig_sel, exp_seg[i]);
         end
      end
   endtask

   task automatic test_err();
      do_clear();
      strobe(4'd1); strobe(4'd2);
      n_vec++; if (err !== 1'b0) begin n_miss++; $display("FAIL err idle: got %b want 0", err); end
      strobe(4'hA);
      n_vec++; if (err !== 1'b1) begin n_miss++; $display("FAIL err pulse: got %b want 1", err); end
      n_vec++; if (value_bcd !== 16'h0012 || count !== 4'd2) begin n_miss++; $display("FAIL err hold: got %h/%0d want 0012/2", value_bcd, count); end
      @(negedge clk);
      n_vec++; if (err !== 1'b0) begin n_miss++; $display("FAIL err width: got %b want 0", err); end
      strobe(4'hF);
      n_vec++; if (err !== 1'b1) begin n_miss++; $display("FAIL err F: got %b want 1", err); end
      strobe(4'd3);
      n_vec++; if (err !== 1'b0 || value_bcd !== 16'h0123 || count !== 4'd3) begin n_miss++; $display("FAIL err recover: got %b/%h/%0d want 0/0123/3", err, value_bcd, count); end
   endtask

   task automatic test_clear_priority();
      logic [6:0] exp_seg [4];
      bit ok;
      clear = 1'b1; digit_valid = 1'b1; digit_in = 4'd5;
      @(negedge clk);
      clear = 1'b0; digit_valid = 1'b0;
      n_vec++; if (value_bcd !== 16'h0000 || count !== 4'd0 || err !== 1'b0) begin n_miss++; $display("FAIL clear+valid: got %h/%0d/%b want 0000/0/0", value_bcd, count, err); end
      clear = 1'b1; digit_valid = 1'b1; digit_in = 4'hA;
      @(negedge clk);
      clear = 1'b0; digit_valid = 1'b0;
      n_vec++; if (err !== 1'b0 || count !== 4'd0) begin n_miss++; $display("FAIL clear+bad digit: got err %b count %0d want 0/0", err, count); end
      @(negedge clk);
      exp_seg = '{7'h3F, 7'h00, 7'h00, 7'h00};
      for (int i = 0; i < 4; i++) begin
         wait_sel(i, ok);
         n_vec++;
         if (!ok || seg !== exp_seg[i]) begin
            n_miss++;
            $display("FAIL clear display digit %0d: seg %h dig_sel %b want seg %h", i, seg, dig_sel, exp_seg[i]);
         end
      end
   endtask

   task automatic test_async_reset();
      bit ok;
      strobe(4'd1); strobe(4'd2); strobe(4'd3);
      wait_sel(2, ok);
      n_vec++; if (!ok) begin n_miss++; $display("FAIL async setup: dig_sel %b never reached 0100", dig_sel); end
      #2 rst_n = 1'b0;
      #1;
      n_vec++; if (value_bcd !== 16'h0000 || count !== 4'd0 || err !== 1'b0) begin n_miss++; $display("FAIL async entry: got %h/%0d/%b want 0000/0/0", value_bcd, count, err); end
      n_vec++; if (seg !== 7'h00 || dig_sel !== 4'b0001) begin n_miss++; $display("FAIL async display: got seg %h dig_sel %b want 00/0001", seg, dig_sel); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 1; n <= 5; n++) begin
         @(negedge clk);
         if (n == 1) begin
            n_vec++; if (seg !== 7'h3F || dig_sel !== 4'b0001) begin n_miss++; $display("FAIL async restart edge 1: seg %h dig_sel %b want 3F/0001", seg, dig_sel); end
         end
         if (n == 4) begin
            n_vec++; if (dig_sel !== 4'b0001) begin n_miss++; $display("FAIL async hold edge 4: dig_sel %b want 0001", dig_sel); end
         end
         if (n == 5) begin
            n_vec++; if (dig_sel !== 4'b0010 || seg !== 7'h00) begin n_miss++; $display("FAIL async advance edge 5: seg %h dig_sel %b want 00/0010", seg, dig_sel); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_entry();
      test_saturate();
      test_err();
      test_clear_priority();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/bcd_digit_display.md
Name: bcd_digit_display

Overview:
- Sits downstream of the 8421 BCD encoder.
- Takes single BCD digits qualified by a strobe and shifts them into a DIGITS-wide entry buffer, like a calculator display.
- Drives a time-multiplexed common-cathode 7-segment display with leading-zero blanking.
- Also exposes the packed BCD value and digit count to downstream logic.

Parameters:
- DIGITS, 4: number of display digits / buffer depth. Legal range 2..8.
- SCAN_DIV, 50000: clk cycles each digit is held during scanning. Minimum 2.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- digit_in  input  4  BCD digit from the encoder.
- digit_valid  input  1  single-cycle strobe; digit_in is sampled when high.
- clear  input  1  synchronous clear of buffer and count.
- value_bcd  output  4*DIGITS  packed buffer; the newest digit is at [3:0].
- count  output  4  number of digits entered, saturating at DIGITS.
- err  output  1  one-cycle pulse when a strobed digit_in is greater than 9.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-high.
- dig_sel  output  DIGITS  one-hot digit enable, active-high; bit 0 is the rightmost (newest) digit.

Behaviour:
- Reset (rst_n low, asynchronous) sets:
  - value_bcd = 0, count = 0, err = 0
  - prescaler = 0, scan index = 0
  - dig_sel = 1 (one-hot bit 0), seg = 7'b0000000
- Entry register, evaluated each cycle in this priority order:
  1. clear: value_bcd <= 0, count <= 0, err <= 0. Any simultaneous digit_valid is dropped and err is not raised.
  2. digit_valid with digit_in <= 9:
     - value_bcd <= {value_bcd[4*DIGITS-5:0], digit_in}
     - count <= min(count+1, DIGITS)
     - When full, the oldest digit falls off the top and count stays at DIGITS.
  3. digit_valid with digit_in > 9: buffer and count unchanged; err <= 1 for exactly one cycle.
  4. Otherwise: hold; err <= 0.
- Entered zeros count as digits: entering 0, 0 gives count = 2.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - On the terminal count, the scan index advances (DIGITS-1 wraps to 0).
  - clear and digit_valid do not affect scanning.
- Display pipeline (one registered stage):
  - seg and dig_sel update on the clock edge after the scan index changes; they are registered outputs with no glitches.
  - Selected digit i = value_bcd[4i+3:4i].
  - Blanking: if i >= count, seg = 0 (blank).
  - Exception: i == 0 with count == 0 shows '0' (7'b0111111).
  - dig_sel = 1 << i.
- Segment encoding:
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66
  - 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F
  - Values above 9 never reach the buffer; the decoder still maps them to 0.
- Latency:
  - value_bcd and count reflect an entered digit 1 cycle after the strobe.
  - seg reflects a buffer change at most 1 cycle after it, while that digit is selected.
- Reset mid-scan: all state returns to reset values immediately; scanning restarts from digit 0 with a fresh SCAN_DIV period.

Decomposition:
- Shared package bcd_pkg holds:
  - localparam segment constants SEG_0..SEG_9 and SEG_BLANK
  - BCD_MAX = 9
  - the count width constant (4)
- Sub-module bcd_to_seg7: purely combinational 4-bit BCD to 7-segment decoder, reused by other display blocks.
- Entry buffer, prescaler and scan/blank logic remain in bcd_digit_display.

Test Plan:
- Reset release, no input (DIGITS = 4, SCAN_DIV = 4):
  - dig_sel cycles 0001 → 0010 → 0100 → 1000 → 0001, 4 clk each.
  - seg = 3F on digit 0 and 00 on the other digits.
- Strobe 1, 2, 3 (one cycle apart):
  - value_bcd = 16'h0123, count = 3.
  - Digits 0..2 show 4F, 5B, 06; digit 3 is blank.
- Strobe 9, 8, 7, 6, 5:
  - value_bcd = 16'h8765, count = 4 (saturated); the 9 is dropped.
- Strobe digit_in = 4'hA with value 16'h0012:
  - err high for exactly 1 cycle; value_bcd stays 16'h0012; count stays 2.
- clear and digit_valid (digit 5) in the same cycle:
  - value_bcd = 0, count = 0, err = 0.
  - Display returns to a single '0' next scan.
- Assert rst_n low asynchronously mid-prescale with count = 3:
  - All outputs go to reset values without a clock edge.
  - After release, the first digit advance happens after exactly SCAN_DIV cycles.
